// File: rtl/divrem_seq_unit_if.sv
// Start/ready handshake and operand bundle between the EX stage and the
// iterative divide/remainder unit.
interface divrem_seq_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             iStart;
   logic [2:0]       iFunct3;
   logic [WIDTH-1:0] iA;
   logic [WIDTH-1:0] iB;
   logic             iAbort;
   logic             oReady;
   logic [WIDTH-1:0] oResult;
   logic             oBusy;

   modport master (
      output iStart, iFunct3, iA, iB, iAbort,
      input  oReady, oResult, oBusy
   );

   modport slave (
      input  iStart, iFunct3, iA, iB, iAbort,
      output oReady, oResult, oBusy
   );
endinterface

// File: rtl/divrem_seq_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring radix-2 division, one quotient bit
// per clock, with a one-cycle oReady completion pulse for the EX stall logic.
module divrem_seq_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNTW  = 6
) (
   input logic             iCLK,
   input logic             iRST,
   divrem_seq_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t state, state_next;

   logic [WIDTH-2:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] div_q;
   logic [CNTW-1:0]  cnt;
   logic             rem_sel, qneg, rneg;
   logic [WIDTH-1:0] result;
   logic             ready;

   // acceptance-side decode
   logic             accept, sgn, fast;
   logic [WIDTH-1:0] abs_a, abs_b, fast_val;

   // one restoring step
   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] rem_next, quo_next, final_val;
   logic             last_iter;

   always_comb begin
      sgn      = bus.iFunct3[2] & ~bus.iFunct3[0];
      accept   = (state == IDLE) && bus.iStart && !bus.iAbort;
      abs_a    = (sgn && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
      abs_b    = (sgn && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
      fast     = 1'b0;
      fast_val = '0;
      if (bus.iB == '0) begin
         fast     = 1'b1;
         fast_val = bus.iFunct3[1] ? bus.iA : '1;
      end else if (sgn && bus.iA == MIN_NEG && bus.iB == '1) begin
         fast     = 1'b1;
         fast_val = bus.iFunct3[1] ? '0 : MIN_NEG;
      end
   end

   always_comb begin
      shifted   = {rem_q, quo_q[WIDTH-1]};
      diff      = {1'b0, shifted} - {1'b0, div_q};
      borrow    = diff[WIDTH];
      rem_next  = borrow ? shifted : diff[WIDTH-1:0];
      quo_next  = {quo_q[WIDTH-2:0], ~borrow};
      if (rem_sel) final_val = rneg ? -rem_next : rem_next;
      else         final_val = qneg ? -quo_next : quo_next;
      last_iter = (cnt == CNTW'(WIDTH - 1));
   end

   always_ff @(posedge iCLK) begin
      if (iRST) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (bus.iAbort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.iStart) state_next = fast ? DONE : CALC;
            CALC:    if (last_iter)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      ready       = (state == DONE);
      bus.oReady  = ready;
      bus.oBusy   = bus.iStart & ~ready;
      bus.oResult = result;
   end

   // The partial remainder entering a shift is always below 2^(WIDTH-1), so
   // its MSB is never needed and the register is kept one bit narrower.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         cnt     <= '0;
         rem_sel <= 1'b0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         result  <= '0;
      end else if (accept) begin
         rem_sel <= bus.iFunct3[1];
         qneg    <= sgn & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
         rneg    <= sgn & bus.iA[WIDTH-1];
         rem_q   <= '0;
         quo_q   <= abs_a;
         div_q   <= abs_b;
         cnt     <= '0;
         if (fast) result <= fast_val;
      end else if (state == CALC && !bus.iAbort) begin
         rem_q <= rem_next[WIDTH-2:0];
         quo_q <= quo_next;
         cnt   <= cnt + CNTW'(1);
         if (last_iter) result <= final_val;
      end
   end

endmodule

// File: tb/tb_divrem_seq_unit.sv
// Directed and random checks of divrem_seq_unit latency, results, abort and
// reset behaviour, using an expected-result queue.
module tb_divrem_seq_unit;

   logic iCLK = 1'b0;
   logic iRST;
   always #5 iCLK = ~iCLK;

   divrem_seq_unit_if #(.WIDTH(32)) bus ();

   divrem_seq_unit #(.WIDTH(32), .CNTW(6)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res;

   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101,
                          F_REM = 3'b110, F_REMU = 3'b111;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return f[1] ? 32'd0 : 32'h8000_0000;
      case (f)
         F_DIV:   return 32'($signed(a) / $signed(b));
         F_DIVU:  return a / b;
         F_REM:   return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   // Drive an operation (caller is at a negedge) and record its expectation.
   task automatic issue(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      bus.iStart  = 1'b1;
      bus.iFunct3 = f;
      bus.iA      = a;
      bus.iB      = b;
      exp_q.push_back(exp);
   endtask

   // Count negedges until oReady; oBusy must stay high until then.
   task automatic wait_ready(input string tag, input int unsigned exp_lat);
      int unsigned lat = 0;
      int unsigned busy_low = 0;
      logic [31:0] exp;
      do begin
         @(negedge iCLK);
         lat++;
         if (!bus.oReady && !bus.oBusy) busy_low++;
      end while (!bus.oReady && lat < 200);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_wait"}, 32'(busy_low), 32'd0);
      check({tag, "_busy_done"}, 32'(bus.oBusy), 32'd0);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         exp = exp_q.pop_front();
         check({tag, "_res"}, bus.oResult, exp);
         last_res = exp;
      end
   endtask

   task automatic single(input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int unsigned lat);
      @(negedge iCLK);
      issue(f, a, b, exp);
      wait_ready(tag, lat);
      bus.iStart = 1'b0;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      int unsigned seen;

      iRST = 1'b1;
      bus.iStart = 1'b0; bus.iFunct3 = 3'b000; bus.iA = '0; bus.iB = '0;
      bus.iAbort = 1'b0;
      repeat (3) @(negedge iCLK);
      check("rst_ready", 32'(bus.oReady), 32'd0);
      check("rst_result", bus.oResult, 32'd0);
      check("rst_busy", 32'(bus.oBusy), 32'd0);
      iRST = 1'b0;

      single("div_100_7",  F_DIV,  32'd100, 32'd7, 32'd14, 33);
      @(negedge iCLK);
      check("hold_result", bus.oResult, 32'd14);
      check("idle_ready", 32'(bus.oReady), 32'd0);
      single("rem_100_7",  F_REM,  32'd100, 32'd7, 32'd2, 33);
      single("div_m100_7", F_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
      single("rem_m100_7", F_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
      single("remu_max_2", F_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
      single("divu_max_2", F_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33);
      single("divu_5_0",   F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      single("rem_5_0",    F_REM,  32'd5, 32'd0, 32'd5, 1);
      single("div_ovf",    F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      single("rem_ovf",    F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      single("divu_big",   F_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);

      // abort mid-calculation
      @(negedge iCLK);
      bus.iStart = 1'b1; bus.iFunct3 = F_DIV; bus.iA = 32'd100; bus.iB = 32'd7;
      repeat (10) @(negedge iCLK);
      bus.iAbort = 1'b1; bus.iStart = 1'b0;
      @(negedge iCLK);
      bus.iAbort = 1'b0;
      check("abort_ready", 32'(bus.oReady), 32'd0);
      check("abort_result", bus.oResult, last_res);
      seen = 0;
      repeat (40) begin
         @(negedge iCLK);
         if (bus.oReady) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      single("after_abort", F_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);

      // reset mid-calculation
      @(negedge iCLK);
      bus.iStart = 1'b1; bus.iFunct3 = F_DIV; bus.iA = 32'd100; bus.iB = 32'd7;
      repeat (10) @(negedge iCLK);
      iRST = 1'b1; bus.iStart = 1'b0;
      @(negedge iCLK);
      iRST = 1'b0;
      check("rst_mid_ready", 32'(bus.oReady), 32'd0);
      check("rst_mid_result", bus.oResult, 32'd0);
      single("after_rst", F_REM, 32'd7, 32'd0, 32'd7, 1);

      // back-to-back with iStart held across the DONE cycle
      @(negedge iCLK);
      issue(F_DIV, 32'd100, 32'd7, 32'd14);
      wait_ready("b2b_first", 33);
      issue(F_REM, 32'd9, 32'd4, 32'd1);
      wait_ready("b2b_second", 34);
      bus.iStart = 1'b0;

      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i % 3 == 0) rb = -rb;
         rf = 3'b100 | 3'($urandom_range(0, 3));
         single("rand", rf, ra, rb, model(rf, ra, rb), 33);
      end

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
